// File: rtl/qupls_pred_regfile.sv
// Predicate/mask register file and scoreboard for Rm selectors 48..48+NPRED-1.
// Define QUPLS_PRED_BYPASS_EN to forward same-cycle accepted writebacks to the read ports.
module qupls_pred_regfile #(
  parameter int unsigned WID   = 64,
  parameter int unsigned NPRED = 8,
  parameter int unsigned TAGW  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [7:0]      rd0_regno,
  output logic [WID-1:0]  rd0_val,
  output logic            rd0_rdy,
  input  logic [7:0]      rd1_regno,
  output logic [WID-1:0]  rd1_val,
  output logic            rd1_rdy,
  input  logic            iss_v,
  input  logic [7:0]      iss_regno,
  input  logic [TAGW-1:0] iss_tag,
  input  logic            wb0_v,
  input  logic [7:0]      wb0_regno,
  input  logic [TAGW-1:0] wb0_tag,
  input  logic [WID-1:0]  wb0_val,
  input  logic            wb1_v,
  input  logic [7:0]      wb1_regno,
  input  logic [TAGW-1:0] wb1_tag,
  input  logic [WID-1:0]  wb1_val,
  output logic [3:0]      pend_cnt
);

  localparam int unsigned IW = (NPRED > 1) ? $clog2(NPRED) : 1;
  typedef logic [IW-1:0] idx_t;

  // Out-of-range selectors collapse onto the hardwired no-predicate entry.
  function automatic idx_t regidx(input logic [7:0] regno);
    if (regno >= 8'd48 && int'(regno) < 48 + int'(NPRED))
      return idx_t'(regno - 8'd48);
    return '0;
  endfunction

  logic [WID-1:0]  val   [NPRED];
  logic [TAGW-1:0] tag   [NPRED];
  logic [NPRED-1:0] pend;

  logic [WID-1:0]  val_n [NPRED];
  logic [TAGW-1:0] tag_n [NPRED];
  logic [NPRED-1:0] pend_n;
  logic [NPRED-1:0] acc0, acc1;
  logic [3:0]       cnt_n;

  idx_t ii, wi0, wi1, ri0, ri1;
  logic [WID-1:0] r0_val, r1_val;
  logic           r0_rdy, r1_rdy;

  assign ii  = regidx(iss_regno);
  assign wi0 = regidx(wb0_regno);
  assign wi1 = regidx(wb1_regno);
  assign ri0 = regidx(rd0_regno);
  assign ri1 = regidx(rd1_regno);

  always_comb begin
    val_n  = val;
    tag_n  = tag;
    pend_n = pend;
    acc0   = '0;
    acc1   = '0;
    for (int unsigned i = 1; i < NPRED; i++) begin
      acc0[i] = wb0_v && wi0 == idx_t'(i) && pend[i] && tag[i] == wb0_tag;
      acc1[i] = wb1_v && wi1 == idx_t'(i) && pend[i] && tag[i] == wb1_tag;
      if (acc1[i]) begin
        val_n[i]  = wb1_val;
        pend_n[i] = 1'b0;
      end
      if (acc0[i]) begin
        val_n[i]  = wb0_val;
        pend_n[i] = 1'b0;
      end
      // A same-cycle issue re-arms the entry after its old producer retires.
      if (iss_v && !flush && ii == idx_t'(i)) begin
        pend_n[i] = 1'b1;
        tag_n[i]  = iss_tag;
      end
    end
    if (flush)
      pend_n = '0;
  end

  always_comb begin
    cnt_n = '0;
    for (int unsigned i = 0; i < NPRED; i++)
      cnt_n = cnt_n + 4'(pend_n[i]);
  end

  always_comb begin
    r0_val = val[ri0];
    r0_rdy = !pend[ri0];
    r1_val = val[ri1];
    r1_rdy = !pend[ri1];
`ifdef QUPLS_PRED_BYPASS_EN
    if (acc1[ri0]) begin r0_val = wb1_val; r0_rdy = 1'b1; end
    if (acc0[ri0]) begin r0_val = wb0_val; r0_rdy = 1'b1; end
    if (acc1[ri1]) begin r1_val = wb1_val; r1_rdy = 1'b1; end
    if (acc0[ri1]) begin r1_val = wb0_val; r1_rdy = 1'b1; end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NPRED; i++) begin
        val[i] <= (i == 0) ? '1 : '0;
        tag[i] <= '0;
      end
      pend     <= '0;
      pend_cnt <= '0;
      rd0_val  <= '0;
      rd0_rdy  <= 1'b0;
      rd1_val  <= '0;
      rd1_rdy  <= 1'b0;
    end else begin
      val      <= val_n;
      tag      <= tag_n;
      pend     <= pend_n;
      pend_cnt <= cnt_n;
      rd0_val  <= r0_val;
      rd0_rdy  <= r0_rdy;
      rd1_val  <= r1_val;
      rd1_rdy  <= r1_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      assert (!(|(acc0 & acc1)));
  end

endmodule

// File: tb/tb_qupls_pred_regfile.sv
// Directed-vector bench for qupls_pred_regfile; expected values are hand-computed.
module tb_qupls_pred_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [7:0]  rd0_regno, rd1_regno;
  logic [63:0] rd0_val, rd1_val;
  logic        rd0_rdy, rd1_rdy;
  logic        iss_v;
  logic [7:0]  iss_regno;
  logic [5:0]  iss_tag;
  logic        wb0_v, wb1_v;
  logic [7:0]  wb0_regno, wb1_regno;
  logic [5:0]  wb0_tag, wb1_tag;
  logic [63:0] wb0_val, wb1_val;
  logic [3:0]  pend_cnt;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  qupls_pred_regfile #(.WID(64), .NPRED(8), .TAGW(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rd0_regno(rd0_regno), .rd0_val(rd0_val), .rd0_rdy(rd0_rdy),
    .rd1_regno(rd1_regno), .rd1_val(rd1_val), .rd1_rdy(rd1_rdy),
    .iss_v(iss_v), .iss_regno(iss_regno), .iss_tag(iss_tag),
    .wb0_v(wb0_v), .wb0_regno(wb0_regno), .wb0_tag(wb0_tag), .wb0_val(wb0_val),
    .wb1_v(wb1_v), .wb1_regno(wb1_regno), .wb1_tag(wb1_tag), .wb1_val(wb1_val),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    iss_v = 1'b0; iss_regno = '0; iss_tag = '0;
    wb0_v = 1'b0; wb0_regno = '0; wb0_tag = '0; wb0_val = '0;
    wb1_v = 1'b0; wb1_regno = '0; wb1_tag = '0; wb1_val = '0;
  endtask

  task automatic issue(input logic [7:0] r, input logic [5:0] t);
    iss_v = 1'b1; iss_regno = r; iss_tag = t;
    tick();
    iss_v = 1'b0;
  endtask

  initial begin
    idle();
    rd0_regno = 8'd48; rd1_regno = 8'd51;
    rst_n = 1'b0;
    #12;
    check("rst_rd0_val", rd0_val, 64'h0);
    check("rst_rd0_rdy", 64'(rd0_rdy), 64'd0);
    check("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset contents
    tick();
    check("r48_val", rd0_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("r48_rdy", 64'(rd0_rdy), 64'd1);
    check("r51_val", rd1_val, 64'h0);
    check("r51_rdy", 64'(rd1_rdy), 64'd1);
    check("idle_cnt", 64'(pend_cnt), 64'd0);

    // Issue then matching writeback two cycles later
    rd0_regno = 8'd50;
    issue(8'd50, 6'd5);
    check("iss50_cnt", 64'(pend_cnt), 64'd1);
    tick();
    check("iss50_rdy", 64'(rd0_rdy), 64'd0);
    wb0_v = 1'b1; wb0_regno = 8'd50; wb0_tag = 6'd5; wb0_val = 64'hF0F0;
    tick();
    idle();
`ifdef QUPLS_PRED_BYPASS_EN
    check("byp50_val", rd0_val, 64'hF0F0);
    check("byp50_rdy", 64'(rd0_rdy), 64'd1);
`else
    check("nobyp50_rdy", 64'(rd0_rdy), 64'd0);
`endif
    tick();
    check("wb50_val", rd0_val, 64'hF0F0);
    check("wb50_rdy", 64'(rd0_rdy), 64'd1);
    check("wb50_cnt", 64'(pend_cnt), 64'd0);

    // Reissue: only the newest tag retires the entry
    rd0_regno = 8'd52;
    issue(8'd52, 6'd3);
    issue(8'd52, 6'd9);
    check("reiss_cnt", 64'(pend_cnt), 64'd1);
    wb0_v = 1'b1; wb0_regno = 8'd52; wb0_tag = 6'd3; wb0_val = 64'h1;
    tick();
    idle();
    tick();
    check("stale_val", rd0_val, 64'h0);
    check("stale_rdy", 64'(rd0_rdy), 64'd0);
    check("stale_cnt", 64'(pend_cnt), 64'd1);
    wb1_v = 1'b1; wb1_regno = 8'd52; wb1_tag = 6'd9; wb1_val = 64'h2;
    tick();
    idle();
    tick();
    check("new_val", rd0_val, 64'h2);
    check("new_rdy", 64'(rd0_rdy), 64'd1);
    check("new_cnt", 64'(pend_cnt), 64'd0);

    // Flush clears pending, drops same-cycle issue
    issue(8'd49, 6'd1);
    issue(8'd53, 6'd2);
    check("pre_flush_cnt", 64'(pend_cnt), 64'd2);
    flush = 1'b1;
    iss_v = 1'b1; iss_regno = 8'd55; iss_tag = 6'd3;
    tick();
    idle();
    check("flush_cnt", 64'(pend_cnt), 64'd0);
    rd0_regno = 8'd49; rd1_regno = 8'd55;
    tick();
    check("flush49_rdy", 64'(rd0_rdy), 64'd1);
    check("flush49_val", rd0_val, 64'h0);
    check("flush55_rdy", 64'(rd1_rdy), 64'd1);
    wb0_v = 1'b1; wb0_regno = 8'd49; wb0_tag = 6'd1; wb0_val = 64'h77;
    tick();
    idle();
    tick();
    check("postflush_wb_val", rd0_val, 64'h0);
    check("postflush_wb_rdy", 64'(rd0_rdy), 64'd1);

    // Same-cycle issue and matching writeback on one register
    rd0_regno = 8'd54;
    issue(8'd54, 6'd4);
    check("iss54_cnt", 64'(pend_cnt), 64'd1);
    iss_v = 1'b1; iss_regno = 8'd54; iss_tag = 6'd7;
    wb0_v = 1'b1; wb0_regno = 8'd54; wb0_tag = 6'd4; wb0_val = 64'hAA;
    tick();
    idle();
    check("isswb_cnt", 64'(pend_cnt), 64'd1);
    tick();
    check("isswb_val", rd0_val, 64'hAA);
    check("isswb_rdy", 64'(rd0_rdy), 64'd0);
    wb0_v = 1'b1; wb0_regno = 8'd54; wb0_tag = 6'd7; wb0_val = 64'hBB;
    tick();
    idle();
    tick();
    check("tag7_val", rd0_val, 64'hBB);
    check("tag7_rdy", 64'(rd0_rdy), 64'd1);

    // Two writebacks to different registers in one cycle
    rd0_regno = 8'd50; rd1_regno = 8'd51;
    issue(8'd50, 6'd10);
    issue(8'd51, 6'd11);
    check("dual_pre_cnt", 64'(pend_cnt), 64'd2);
    wb0_v = 1'b1; wb0_regno = 8'd50; wb0_tag = 6'd10; wb0_val = 64'h1234;
    wb1_v = 1'b1; wb1_regno = 8'd51; wb1_tag = 6'd11; wb1_val = 64'h5678;
    tick();
    idle();
    check("dual_cnt", 64'(pend_cnt), 64'd0);
    tick();
    check("dual0_val", rd0_val, 64'h1234);
    check("dual1_val", rd1_val, 64'h5678);
    check("dual1_rdy", 64'(rd1_rdy), 64'd1);

    // Hardwired entry and out-of-range selectors
    issue(8'd48, 6'd1);
    check("iss48_cnt", 64'(pend_cnt), 64'd0);
    issue(8'd200, 6'd2);
    check("iss200_cnt", 64'(pend_cnt), 64'd0);
    wb0_v = 1'b1; wb0_regno = 8'd48; wb0_tag = 6'd0; wb0_val = 64'h0;
    wb1_v = 1'b1; wb1_regno = 8'd200; wb1_tag = 6'd2; wb1_val = 64'h0;
    rd0_regno = 8'd48; rd1_regno = 8'd200;
    tick();
    idle();
    tick();
    check("r48_hw_val", rd0_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("r48_hw_rdy", 64'(rd0_rdy), 64'd1);
    check("r200_val", rd1_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("r200_rdy", 64'(rd1_rdy), 64'd1);

    // Asynchronous reset mid-operation
    rd0_regno = 8'd52;
    issue(8'd52, 6'd3);
    check("mid_cnt", 64'(pend_cnt), 64'd1);
    wb0_v = 1'b1; wb0_regno = 8'd52; wb0_tag = 6'd3; wb0_val = 64'h99;
    rst_n = 1'b0;
    #1;
    check("async_cnt", 64'(pend_cnt), 64'd0);
    check("async_rdy", 64'(rd0_rdy), 64'd0);
    idle();
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_val", rd0_val, 64'h0);
    check("post_rst_rdy", 64'(rd0_rdy), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/qupls_pred_regfile.md
Name: qupls_pred_regfile

Overview:
- Predicate/mask register file and scoreboard. It answers the Rm predicate-register selectors that the decoders produce (architectural registers 48..55, i.e. 48 | Pr).
- Decoders present Rm on the read ports; the block returns the mask value and a ready bit.
- Dispatch marks a predicate as pending with a producer tag.
- Compare/logic units write results back by tag.
- Sits between decode/rename and the issue queues. It gates issue of predicated ops until their mask is valid.

Parameters:
- WID, 64, predicate mask width in bits.
- NPRED, 8, number of predicate registers (architectural 48..48+NPRED-1).
- TAGW, 6, producer tag width (ROB index).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; discard all pending producers
- rd0_regno  in  8  Rm selector, read port 0
- rd0_val  out  WID  mask value, port 0
- rd0_rdy  out  1  value valid (no pending producer), port 0
- rd1_regno  in  8  Rm selector, read port 1
- rd1_val  out  WID  mask value, port 1
- rd1_rdy  out  1  ready, port 1
- iss_v  in  1  dispatch marks a predicate destination pending
- iss_regno  in  8  destination predicate register
- iss_tag  in  TAGW  producer tag
- wb0_v  in  1  writeback valid, port 0
- wb0_regno  in  8  writeback register, port 0
- wb0_tag  in  TAGW  writeback tag, port 0
- wb0_val  in  WID  writeback value, port 0
- wb1_v, wb1_regno, wb1_tag, wb1_val  in  1/8/TAGW/WID  writeback port 1, same meaning as port 0
- pend_cnt  out  4  number of registers currently pending

Behaviour:
- Index = regno - 48.
  - regno outside 48..48+NPRED-1 maps to index 0.
  - Index 0 (Rm=48, the default/no-predicate selector) is hardwired: value all-ones, never pending. Issue and writeback to it are ignored.
- Reset (async, rst_n low):
  - val[0] all-ones; val[1..NPRED-1] = 0.
  - All pend = 0; all tags = 0.
  - rd*_val = 0, rd*_rdy = 0, pend_cnt = 0.
- Reads are registered, 1-cycle latency: in cycle N+1, rdX_val = val[idx] and rdX_rdy = !pend[idx], sampled in cycle N.
- Issue (iss_v, idx != 0): pend[idx] <= 1, tag[idx] <= iss_tag. Reissue to an already-pending register overwrites the tag (newest producer wins).
- Writeback (wbX_v, idx != 0):
  - Accepted only if pend[idx] && tag[idx] == wbX_tag: val[idx] <= wbX_val, pend[idx] <= 0.
  - Stale tag or not pending: ignored, no state change.
- Simultaneous issue and matching writeback, same register: val updated, pend stays 1, tag takes iss_tag.
- Both writeback ports hit the same register with the matching tag: wb0 wins. A simulation assertion flags the event as a protocol error.
- Two writebacks to different registers in the same cycle: both accepted.
- flush: all pend <= 0 next edge; values and tags unchanged.
  - Issue in the flush cycle is dropped.
  - Writebacks in the flush cycle are still applied if their tags match.
- pend_cnt: registered population count of pend, consistent with the pend state after the same edge.
- rst_n asserted mid-operation: immediate return to reset state; in-flight writebacks are lost.

Optional Feature:
- QUPLS_PRED_BYPASS_EN defined: a read whose register matches an accepted writeback in the same cycle returns wb_val with rdy = 1 at N+1.
  - If both ports hit, wb0 has priority.
  - Effective read-after-writeback latency: 1 cycle.
- Undefined: no forwarding. The new value and rdy = 1 appear on the read port two cycles after the writeback cycle.

Test Plan:
- Reset then read rd0_regno=48, rd1_regno=51 -> next cycle rd0_val=all-ones, rd0_rdy=1; rd1_val=0, rd1_rdy=1; pend_cnt=0.
- iss_v regno=50 tag=5; wb0 regno=50 tag=5 val=0xF0F0 two cycles later -> reads show rdy=0 until the writeback, then val=0xF0F0, rdy=1. Bypass on: visible 1 cycle after the writeback cycle; bypass off: 2 cycles after.
- Issue regno=52 tag=3, reissue tag=9, then wb tag=3 val=0x1 -> ignored, still pending; wb tag=9 val=0x2 -> val=0x2, rdy=1.
- Issue regno=49 tag=1 and regno=53 tag=2, flush -> pend_cnt=0, rdy=1, values unchanged; later wb tag=1 to 49 -> ignored.
- Same cycle: iss regno=54 tag=7 and wb0 regno=54 matching old tag 4 val=0xAA -> val=0xAA, rdy=0, tag=7, pend_cnt unchanged.
- Issue/wb to regno=48 and regno=200 -> no state change; reads return all-ones, rdy=1.
